// File: rtl/hit_ts_capture.sv
// Per-layer hit receiver: timestamps each hit_dv sample and queues {ts, layer, hit} in a FWFT FIFO.
// Optional build macro HIT_ZERO_FILTER_EN discards all-zero payloads before the FIFO.
module hit_ts_capture #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_OFFSET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ts_clr,
  input  logic [5:0]               layer,
  input  logic                     hit_dv,
  input  logic [23:0]              hit_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_ts,
  output logic [2:0]               rd_layer,
  output logic [23:0]              rd_hit,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned RW       = 32 + 3 + 24;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_EMPTY, S_HAVE} state_t;

  state_t         state;
  logic [31:0]    ts_cnt;
  logic [RW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_ptr_nxt;
  logic [AW:0]    count_nxt;
  logic [2:0]     layer_enc;
  logic           hit_in;
  logic           pop;
  logic           wr_ok;
  logic           drop;
  logic           load_head;
  logic [RW-1:0]  wr_rec;
  logic [RW-1:0]  head_nxt;

  // Descending scan so the lowest set bit is the last one to assign.
  always_comb begin
    layer_enc = '0;
    for (int unsigned i = 6; i > 0; i--) begin
      if (layer[i-1]) layer_enc = 3'(i - 1);
    end
  end

  always_comb begin
`ifdef HIT_ZERO_FILTER_EN
    hit_in = hit_dv && (hit_data != '0);
`else
    hit_in = hit_dv;
`endif
  end

  always_comb begin
    pop        = rd_valid && rd_ready;
    wr_ok      = hit_in && ((fifo_count != FULL_CNT) || pop);
    drop       = hit_in && !wr_ok;
    wr_rec     = {ts_cnt - TS_OFFSET, layer_enc, hit_data};
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = fifo_count + (AW+1)'(wr_ok) - (AW+1)'(pop);
    // Output registers mirror the head; when the queue drains to just the
    // incoming record, it bypasses memory straight into the output stage.
    load_head  = (pop || !rd_valid) && (count_nxt != '0);
    if (fifo_count == (AW+1)'(pop)) head_nxt = wr_rec;
    else                            head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
    end else if (ts_clr) begin
      ts_cnt <= '0;
    end else if (en) begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      rd_valid <= 1'b0;
      rd_ts    <= '0;
      rd_layer <= '0;
      rd_hit   <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (wr_ok) begin
            state    <= S_HAVE;
            rd_valid <= 1'b1;
          end
        end
        S_HAVE: begin
          if (pop && (fifo_count == (AW+1)'(1)) && !wr_ok) begin
            state    <= S_EMPTY;
            rd_valid <= 1'b0;
          end
        end
        default: begin
          state    <= S_EMPTY;
          rd_valid <= 1'b0;
        end
      endcase
      if (load_head) {rd_ts, rd_layer, rd_hit} <= head_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hit_ts_capture.sv
// Scoreboard bench for hit_ts_capture: expected records are queued as hits are driven.
module tb_hit_ts_capture;
  localparam int unsigned DEPTH = 16;

  typedef logic [58:0] rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ts_clr = 1'b0;
  logic [5:0]  layer = '0;
  logic        hit_dv = 1'b0;
  logic [23:0] hit_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_ts;
  logic [2:0]  rd_layer;
  logic [23:0] rd_hit;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] drop_cnt;

  rec_t        sb[$];
  logic [31:0] m_ts;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  hit_ts_capture #(.DEPTH(DEPTH), .TS_OFFSET(1)) dut (
    .clk(clk), .rst(rst), .en(en), .ts_clr(ts_clr), .layer(layer),
    .hit_dv(hit_dv), .hit_data(hit_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_ts(rd_ts), .rd_layer(rd_layer), .rd_hit(rd_hit), .fifo_count(fifo_count),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  function automatic logic [2:0] enc_ref(input logic [5:0] l);
    casez (l)
      6'b?????1: return 3'd0;
      6'b????10: return 3'd1;
      6'b???100: return 3'd2;
      6'b??1000: return 3'd3;
      6'b?10000: return 3'd4;
      6'b100000: return 3'd5;
      default:   return 3'd0;
    endcase
  endfunction

  // Advance one clock from a negedge to the next, updating the model for the edge.
  task automatic tick();
    bit pop_e, hit_e, wr_e;
    pop_e = (sb.size() > 0) && rd_ready;
    hit_e = hit_dv;
`ifdef HIT_ZERO_FILTER_EN
    if (hit_data == 24'h0) hit_e = 1'b0;
`endif
    wr_e = hit_e && ((sb.size() < DEPTH) || pop_e);
    if (pop_e) void'(sb.pop_front());
    if (wr_e) sb.push_back({m_ts - 32'd1, enc_ref(layer), hit_data});
    if (ts_clr) m_ts = 32'd0;
    else if (en) m_ts = m_ts + 32'd1;
    @(posedge clk);
    @(negedge clk);
    hit_dv = 1'b0;
    ts_clr = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_fifo: rd_valid=%b fifo_count=%0d want 0 0", rd_valid, fifo_count);
    end
    n_checks++;
    if ({rd_ts, rd_layer, rd_hit} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%h/%h want all zero", rd_ts, rd_layer, rd_hit);
    end
    n_checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ovf: overflow=%b drop_cnt=%0d want 0 0", overflow, drop_cnt);
    end
    rst = 1'b0;
    sb.delete();
    m_ts = 32'd0;
  endtask

  task automatic test_single();
    en = 1'b1;
    layer = 6'b000100;
    repeat (16) tick();
    hit_dv = 1'b1;
    hit_data = 24'hA5A5A5;
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 32'h0F || rd_layer !== 3'd2 || rd_hit !== 24'hA5A5A5) begin
      n_fail++;
      $display("FAIL single_stamp: valid=%b ts=%h layer=%0d hit=%h want 1 0000000f 2 a5a5a5",
               rd_valid, rd_ts, rd_layer, rd_hit);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b count=%0d want 0 0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] lays [3];
    rec_t got;
    lays[0] = 6'b010000;
    lays[1] = 6'b101000;
    lays[2] = 6'b000000;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      layer = lays[i];
      hit_dv = 1'b1;
      hit_data = 24'hB00000 + 24'(i);
      tick();
    end
    tick();
    n_checks++;
    if (fifo_count !== 5'd3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 3", fifo_count);
    end
    n_checks++;
    if (rd_valid !== 1'b1 || rd_hit !== 24'hB00000 || rd_layer !== 3'd4) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b hit=%h layer=%0d want 1 b00000 4", rd_valid, rd_hit, rd_layer);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got = {rd_ts, rd_layer, rd_hit};
      n_checks++;
      if (rd_valid !== 1'b1 || sb.size() == 0 || got !== sb[0]) begin
        n_fail++;
        $display("FAIL bp_drain%0d: valid=%b got %h want %h", i, rd_valid, got,
                 (sb.size() > 0) ? sb[0] : rec_t'(0));
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: valid=%b want 0", rd_valid);
    end
  endtask

  task automatic test_overflow();
    rec_t got;
    layer = 6'b000001;
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      hit_dv = 1'b1;
      hit_data = 24'h100001 + 24'(i);
      tick();
    end
    n_checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL ovf_state: count=%0d ovf=%b drops=%0d want 16 1 2", fifo_count, overflow, drop_cnt);
    end
    ovf_clr = 1'b1;
    tick();
    n_checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b drops=%0d want 0 0", overflow, drop_cnt);
    end
    hit_dv = 1'b1;
    hit_data = 24'hDEAD01;
    tick();
    n_checks++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL ovf_again: ovf=%b drops=%0d want 1 1", overflow, drop_cnt);
    end
    hit_dv = 1'b1;
    hit_data = 24'hDEAD02;
    ovf_clr = 1'b1;
    tick();
    n_checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0 || fifo_count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_drop_clr: ovf=%b drops=%0d count=%0d want 0 0 16", overflow, drop_cnt, fifo_count);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got = {rd_ts, rd_layer, rd_hit};
      n_checks++;
      if (rd_valid !== 1'b1 || sb.size() == 0 || got !== sb[0] || rd_hit !== 24'h100001 + 24'(i)) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: valid=%b got %h want hit %h", i, rd_valid, got, 24'h100001 + 24'(i));
      end
      tick();
    end
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL ovf_empty: valid=%b count=%0d want 0 0", rd_valid, fifo_count);
    end
    rd_ready = 1'b0;
    hit_dv = 1'b1;
    hit_data = 24'h0C1EA7;
    ovf_clr = 1'b1;
    tick();
    got = {rd_ts, rd_layer, rd_hit};
    n_checks++;
    if (fifo_count !== 5'd1 || sb.size() != 1 || got !== sb[0]) begin
      n_fail++;
      $display("FAIL ovf_clr_write: count=%0d got %h want 1 %h", fifo_count, got,
               (sb.size() > 0) ? sb[0] : rec_t'(0));
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    rec_t got;
    int n;
    layer = 6'b100000;
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hit_dv = 1'b1;
      hit_data = 24'h300000 + 24'(i);
      tick();
    end
    rd_ready = 1'b1;
    hit_dv = 1'b1;
    hit_data = 24'hBEEF01;
    tick();
    n_checks++;
    if (fifo_count !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_state: count=%0d drops=%0d ovf=%b want 16 0 0", fifo_count, drop_cnt, overflow);
    end
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      got = {rd_ts, rd_layer, rd_hit};
      n_checks++;
      if (rd_valid !== 1'b1 || got !== sb[0] || (sb.size() == 1 && rd_hit !== 24'hBEEF01)) begin
        n_fail++;
        $display("FAIL fullpop_drain%0d: valid=%b got %h want %h", n, rd_valid, got, sb[0]);
      end
      tick();
      n++;
    end
    n_checks++;
    if (n != 16 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_len: drained %0d valid=%b want 16 0", n, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] want [4];
    rec_t got;
    want[0] = 32'hFFFFFFFE;
    want[1] = 32'hFFFFFFFF;
    want[2] = 32'h00000000;
    want[3] = 32'hFFFFFFFF;
    layer = 6'b000010;
    en = 1'b0;
    force dut.ts_cnt = 32'hFFFFFFFF;
    #1 release dut.ts_cnt;
    m_ts = 32'hFFFFFFFF;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hit_dv = 1'b1;
      hit_data = 24'h111111 * 24'(i + 1);
      tick();
    end
    ts_clr = 1'b1;
    tick();
    hit_dv = 1'b1;
    hit_data = 24'h444444;
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = {rd_ts, rd_layer, rd_hit};
      n_checks++;
      if (rd_valid !== 1'b1 || rd_ts !== want[i] || sb.size() == 0 || got !== sb[0]) begin
        n_fail++;
        $display("FAIL counter_ts%0d: valid=%b ts=%h want %h", i, rd_valid, rd_ts, want[i]);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    layer = 6'b001000;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hit_dv = 1'b1;
      hit_data = 24'h500000 + 24'(i);
      tick();
    end
    n_checks++;
    if (fifo_count !== 5'd5) begin
      n_fail++;
      $display("FAIL arst_fill: count=%0d want 5", fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL arst_clear: valid=%b count=%0d want 0 0", rd_valid, fifo_count);
    end
    sb.delete();
    m_ts = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_payload();
    rec_t got;
    layer = 6'b000001;
    hit_dv = 1'b1;
    hit_data = 24'h000000;
    tick();
    got = {rd_ts, rd_layer, rd_hit};
`ifdef HIT_ZERO_FILTER_EN
    n_checks++;
    if (fifo_count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_filtered: count=%0d valid=%b ovf=%b drops=%0d want 0 0 0 0",
               fifo_count, rd_valid, overflow, drop_cnt);
    end
`else
    n_checks++;
    if (fifo_count !== 5'd1 || rd_valid !== 1'b1 || sb.size() != 1 || got !== sb[0]) begin
      n_fail++;
      $display("FAIL zero_queued: count=%0d valid=%b got %h want 1 1 %h", fifo_count, rd_valid, got,
               (sb.size() > 0) ? sb[0] : rec_t'(0));
    end
`endif
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ts = 32'd0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_counter();
    test_async_reset();
    test_zero_payload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
